// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned MASTER_CPU = 0;
  localparam int unsigned MASTER_DMA = 1;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: one-hot grant from requests and
// the identity of the previously granted master.
module rr_pick2
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,  // 1 when the DMA engine was granted last
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_req[MASTER_CPU] && (!i_req[MASTER_DMA] || i_last_grant)) begin
      o_grant[MASTER_CPU] = 1'b1;
    end else if (i_req[MASTER_DMA]) begin
      o_grant[MASTER_DMA] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter issuing single-cycle read/write strobes,
// with a watchdog that terminates unanswered reads.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_write,
  input  logic [31:0] i_address0,
  input  logic [31:0] i_address1,
  input  logic [31:0] i_write_data0,
  input  logic [31:0] i_write_data1,
  output logic [1:0]  o_ack,
  output logic        o_error,
  output logic [31:0] o_read_data,
  output logic [1:0]  o_grant,
  output logic        o_bus_read,
  output logic        o_bus_write,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_write_data,
  input  logic        i_bus_read_valid,
  input  logic [31:0] i_bus_read_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state, w_state_d;
  logic [1:0]        r_grant, w_grant_d;
  logic [1:0]        r_ack, w_ack_d;
  logic              r_error, w_error_d;
  logic              r_bus_read, w_bus_read_d;
  logic              r_bus_write, w_bus_write_d;
  logic [31:0]       r_address, w_address_d;
  logic [31:0]       r_write_data, w_write_data_d;
  logic [31:0]       r_read_data, w_read_data_d;
  logic [CNT_W-1:0]  r_count, w_count_d;
  logic              r_last_dma, w_last_dma_d;
  logic              r_is_write, w_is_write_d;
  logic [1:0]        w_pick;

  rr_pick2 u_pick (
    .i_req        (i_req),
    .i_last_grant (r_last_dma),
    .o_grant      (w_pick)
  );

  always_comb begin
    w_state_d      = r_state;
    w_grant_d      = r_grant;
    w_ack_d        = 2'b00;
    w_error_d      = r_error;
    w_bus_read_d   = 1'b0;
    w_bus_write_d  = 1'b0;
    w_address_d    = r_address;
    w_write_data_d = r_write_data;
    w_read_data_d  = r_read_data;
    w_count_d      = r_count;
    w_last_dma_d   = r_last_dma;
    w_is_write_d   = r_is_write;

    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_grant_d    = w_pick;
          w_last_dma_d = w_pick[MASTER_DMA];
          if (w_pick[MASTER_DMA]) begin
            w_is_write_d   = i_write[MASTER_DMA];
            w_address_d    = i_address1;
            w_write_data_d = i_write_data1;
          end else begin
            w_is_write_d   = i_write[MASTER_CPU];
            w_address_d    = i_address0;
            w_write_data_d = i_write_data0;
          end
          // Strobes are registered so they appear during the ISSUE cycle.
          w_bus_write_d = w_is_write_d;
          w_bus_read_d  = !w_is_write_d;
          w_state_d     = StIssue;
        end
      end
      StIssue: begin
        if (r_is_write) begin
          w_error_d = 1'b0;
          w_ack_d   = r_grant;
          w_state_d = StResp;
        end else if (i_bus_read_valid) begin
          w_read_data_d = i_bus_read_data;
          w_error_d     = 1'b0;
          w_ack_d       = r_grant;
          w_state_d     = StResp;
        end else begin
          w_count_d = '0;
          w_state_d = StWait;
        end
      end
      StWait: begin
        // A response arriving on the terminal count still wins over the timeout.
        if (i_bus_read_valid) begin
          w_read_data_d = i_bus_read_data;
          w_error_d     = 1'b0;
          w_ack_d       = r_grant;
          w_state_d     = StResp;
        end else if (r_count == CNT_LAST) begin
          w_read_data_d = TIMEOUT_DATA;
          w_error_d     = 1'b1;
          w_ack_d       = r_grant;
          w_state_d     = StResp;
        end else begin
          w_count_d = r_count + 1'b1;
        end
      end
      StResp: begin
        w_grant_d = 2'b00;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_grant      <= 2'b00;
      r_ack        <= 2'b00;
      r_error      <= 1'b0;
      r_bus_read   <= 1'b0;
      r_bus_write  <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_read_data  <= '0;
      r_count      <= '0;
      r_last_dma   <= 1'b1;
      r_is_write   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_grant      <= w_grant_d;
      r_ack        <= w_ack_d;
      r_error      <= w_error_d;
      r_bus_read   <= w_bus_read_d;
      r_bus_write  <= w_bus_write_d;
      r_address    <= w_address_d;
      r_write_data <= w_write_data_d;
      r_read_data  <= w_read_data_d;
      r_count      <= w_count_d;
      r_last_dma   <= w_last_dma_d;
      r_is_write   <= w_is_write_d;
    end
  end

  assign o_ack            = r_ack;
  assign o_error          = r_error;
  assign o_read_data      = r_read_data;
  assign o_grant          = r_grant;
  assign o_bus_read       = r_bus_read;
  assign o_bus_write      = r_bus_write;
  assign o_bus_address    = r_address;
  assign o_bus_write_data = r_write_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction table with an expected-ack
// scoreboard, plus arbitration and mid-transaction reset sequences.
module tb_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req;
  logic [1:0]  write;
  logic [31:0] address0, address1, write_data0, write_data1;
  logic [1:0]  ack;
  logic        error;
  logic [31:0] read_data;
  logic [1:0]  grant;
  logic        bus_read, bus_write;
  logic [31:0] bus_address, bus_write_data;
  logic        bus_read_valid;
  logic [31:0] bus_read_data;

  int n_vec  = 0;
  int n_miss = 0;

  bus_arbiter #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_req            (req),
    .i_write          (write),
    .i_address0       (address0),
    .i_address1       (address1),
    .i_write_data0    (write_data0),
    .i_write_data1    (write_data1),
    .o_ack            (ack),
    .o_error          (error),
    .o_read_data      (read_data),
    .o_grant          (grant),
    .o_bus_read       (bus_read),
    .o_bus_write      (bus_write),
    .o_bus_address    (bus_address),
    .o_bus_write_data (bus_write_data),
    .i_bus_read_valid (bus_read_valid),
    .i_bus_read_data  (bus_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;          // 0 = CPU, 1 = DMA
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          vdelay;     // cycles after strobe that valid arrives, -1 = never
    logic        spurious;   // valid pulse in the IDLE cycle after the ack
    logic [31:0] bus_rdata;
    logic [1:0]  exp_ack;
    int          exp_lat;    // ack cycle counted from the req cycle
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  ack;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    bit   done;
    req   = v.m ? 2'b10 : 2'b01;
    write = {v.wr, v.wr};
    if (v.m) begin
      address1    = v.addr;
      write_data1 = v.wdata;
    end else begin
      address0    = v.addr;
      write_data0 = v.wdata;
    end
    e.ack       = v.exp_ack;
    e.lat       = v.exp_lat;
    e.err       = v.exp_err;
    e.rdata     = v.exp_rdata;
    e.chk_rdata = !v.wr;
    sb.push_back(e);
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      step();
      bus_read_valid = (v.vdelay >= 0) && (cyc == 1 + v.vdelay);
      bus_read_data  = bus_read_valid ? v.bus_rdata : ~v.bus_rdata;
      if (cyc == 1) begin
        check($sformatf("v%0d strobe_wr", idx), 32'(bus_write), 32'(v.wr));
        check($sformatf("v%0d strobe_rd", idx), 32'(bus_read), 32'(!v.wr));
        check($sformatf("v%0d grant", idx), 32'(grant), 32'(v.exp_ack));
        check($sformatf("v%0d address", idx), bus_address, v.addr);
        if (v.wr) check($sformatf("v%0d wdata", idx), bus_write_data, v.wdata);
      end
      if (cyc == 2) begin
        check($sformatf("v%0d strobe_end", idx), 32'({bus_read, bus_write}), 32'h0);
      end
      if (ack != 2'b00) begin
        done = 1'b1;
        req  = 2'b00;
        if (sb.size() == 0) begin
          check($sformatf("v%0d unexpected_ack", idx), 32'(ack), 32'h0);
        end else begin
          got = sb.pop_front();
          check($sformatf("v%0d ack", idx), 32'(ack), 32'(got.ack));
          check($sformatf("v%0d latency", idx), 32'(cyc), 32'(got.lat));
          check($sformatf("v%0d error", idx), 32'(error), 32'(got.err));
          if (got.chk_rdata) check($sformatf("v%0d rdata", idx), read_data, got.rdata);
        end
      end
    end
    if (!done) begin
      check($sformatf("v%0d ack_timeout", idx), 32'h0, 32'h1);
      sb.delete();
      req = 2'b00;
    end
    step();
    bus_read_valid = v.spurious;
    bus_read_data  = 32'h0123_4567;
    check($sformatf("v%0d idle_grant", idx), 32'({grant, ack}), 32'h0);
    step();
    bus_read_valid = 1'b0;
    check($sformatf("v%0d post_idle", idx), 32'({grant, ack, bus_read}), 32'h0);
    if (!v.wr) check($sformatf("v%0d rdata_held", idx), read_data, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    exp_t got;
    int   acks;
    vecs[0] = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, -1, 1'b0, 32'h0,
                2'b01, 2, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0, 3, 1'b0, 32'hCAFE_0001,
                2'b10, 5, 1'b0, 32'hCAFE_0001};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_3008, 32'h0, -1, 1'b1, 32'h0,
                2'b01, 6, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_400C, 32'h0, 0, 1'b0, 32'h0BAD_F00D,
                2'b10, 2, 1'b0, 32'h0BAD_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_5010, 32'h0, 4, 1'b0, 32'h5555_AAAA,
                2'b01, 6, 1'b0, 32'h5555_AAAA};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_6014, 32'hA5A5_0F0F, -1, 1'b0, 32'h0,
                2'b10, 2, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_7018, 32'h0, 1, 1'b1, 32'h7777_0001,
                2'b01, 3, 1'b0, 32'h7777_0001};

    reset_n        = 1'b0;
    req            = 2'b00;
    write          = 2'b00;
    address0       = 32'h0;
    address1       = 32'h0;
    write_data0    = 32'h0;
    write_data1    = 32'h0;
    bus_read_valid = 1'b0;
    bus_read_data  = 32'h0;
    do_reset();

    check("rst grant", 32'(grant), 32'h0);
    check("rst ack", 32'(ack), 32'h0);
    check("rst error", 32'(error), 32'h0);
    check("rst strobes", 32'({bus_read, bus_write}), 32'h0);
    check("rst address", bus_address, 32'h0);
    check("rst wdata", bus_write_data, 32'h0);
    check("rst rdata", read_data, 32'h0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset pulsed low while a read is waiting for its response.
    req      = 2'b01;
    write    = 2'b00;
    address0 = 32'h0000_C0C0;
    repeat (3) step();
    check("wait grant_before", 32'(grant), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst grant", 32'(grant), 32'h0);
    check("arst ack", 32'(ack), 32'h0);
    check("arst address", bus_address, 32'h0);
    check("arst rdata", read_data, 32'h0);
    check("arst error", 32'(error), 32'h0);
    req = 2'b00;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      bus_read_valid = 1'b1;
      bus_read_data  = 32'hBAD0_BAD0;
      step();
      if (ack != 2'b00 || grant != 2'b00) acks++;
    end
    bus_read_valid = 1'b0;
    check("late_valid no_ack", 32'(acks), 32'h0);

    // Both masters requesting continuously: CPU wins first tie, then alternate.
    do_reset();
    write       = 2'b11;
    address0    = 32'h0000_00A0;
    address1    = 32'h0000_00B0;
    write_data0 = 32'h1111_0000;
    write_data1 = 32'h2222_0000;
    req         = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e.ack       = (k % 2 == 0) ? 2'b01 : 2'b10;
      e.lat       = 3 * k + 2;
      e.err       = 1'b0;
      e.rdata     = 32'h0;
      e.chk_rdata = 1'b0;
      sb.push_back(e);
    end
    acks = 0;
    for (int cyc = 1; cyc <= 30 && acks < 4; cyc++) begin
      step();
      if (ack != 2'b00) begin
        acks++;
        if (acks == 4) req = 2'b00;
        got = sb.pop_front();
        check($sformatf("rr ack%0d", acks), 32'(ack), 32'(got.ack));
        check($sformatf("rr cycle%0d", acks), 32'(cyc), 32'(got.lat));
        check($sformatf("rr addr%0d", acks), bus_address,
              got.ack[1] ? 32'h0000_00B0 : 32'h0000_00A0);
      end
    end
    req = 2'b00;
    check("rr ack_count", 32'(acks), 32'h4);
    repeat (2) step();
    check("rr idle", 32'({grant, ack}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the shared 32-bit peripheral bus. Grants the bus to the CPU (master 0) or the DMA engine (master 1), one transaction at a time, with round-robin fairness. Issues a single-cycle read or write strobe to the address decoder. For reads, it waits for the OR-reduced read-valid and muxed read data from the read-data select block, and returns the data to the granted master. A watchdog terminates reads that no peripheral answers.

## Interface
- TIMEOUT_CYCLES, 255: maximum wait cycles for a read response; legal range 1..65535.
- TIMEOUT_DATA, 32'hDEADBEEF: data returned on a timed-out read.

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  2  per-master request, bit0 = CPU, bit1 = DMA; held high until ack
- write  in  2  per-master direction, 1 = write; stable while req high
- address0 / address1  in  32  per-master address
- writeData0 / writeData1  in  32  per-master write data
- ack  out  2  one-cycle completion pulse to the granted master
- error  out  1  valid with ack: read timed out
- readData  out  32  read data, valid with ack on reads
- grant  out  2  one-hot current owner, 0 when idle
- busRead  out  1  one-cycle read strobe
- busWrite  out  1  one-cycle write strobe
- busAddress  out  32  latched address
- busWriteData  out  32  latched write data
- busReadValid  in  1  OR of peripheral valids (readValid)
- busReadData  in  32  selected peripheral data (dataIn)

## Operation
- FSM states:
  - IDLE: if req != 0, pick a master, latch its write/address/writeData, set grant, go ISSUE.
  - ISSUE: assert busRead or busWrite for exactly this cycle. A write goes to RESP. A read goes to WAIT with the counter cleared, unless busReadValid is already high, in which case it captures busReadData and goes to RESP.
  - WAIT: if busReadValid, capture busReadData, error=0, go RESP. Otherwise, when the counter equals TIMEOUT_CYCLES-1, set readData=TIMEOUT_DATA, error=1, go RESP. Otherwise increment the counter.
  - RESP: ack[granted]=1 for one cycle, then grant=0, go IDLE.
- Arbitration:
  - A single requester always wins.
  - If both request, the winner is the master not granted last.
  - The last-grant register resets to "DMA", so the CPU wins the first tie.
- busReadValid and timeout in the same WAIT cycle: valid wins, error=0.
- busReadValid outside ISSUE(read)/WAIT is ignored and does not disturb state.
- req changes outside IDLE are ignored. A master must drop req on the edge where it samples ack=1; req still high in the following IDLE counts as a new request.
- readData is held from capture until the next capture. It is don't-care on write acks. error is cleared on every non-timeout ack.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It never wraps because it stops at the terminal count.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, grant=0, ack=0, error=0, busRead=0, busWrite=0, busAddress=0, busWriteData=0, readData=0, counter=0, last-grant=DMA.
- Write: req sampled in cycle 0, busWrite in cycle 1, ack in cycle 2, IDLE in cycle 3. Back-to-back writes achieve one transaction per 3 cycles.
- Read with valid in cycle k after the strobe (k≥0; k=0 means the ISSUE cycle): ack at cycle 2+k.
- Read with no response: ack with error=1 at cycle 1+TIMEOUT_CYCLES+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-transaction aborts immediately. No ack is issued; the master must reissue.

## Structure
- bus_arbiter_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - master index constants (MASTER_CPU=0, MASTER_DMA=1)
  - default TIMEOUT_DATA value
- Sub-module rr_pick2: combinational 2-way round-robin picker taking req[1:0] and the last-grant bit, returning a one-hot grant. It is kept separate so it can grow to N masters.

## Test plan
- CPU write alone: req=01, write=01, address0=32'h0000_1000, writeData0=32'h1234_5678. Expect busWrite high for exactly one cycle in cycle 1 with those values, then ack=01 in cycle 2.
- DMA read, valid after 3 wait cycles, busReadData=32'hCAFE_0001. Expect ack=10 with readData=32'hCAFE_0001 and error=0 in cycle 5.
- Both requesting continuously after reset: grants alternate CPU, DMA, CPU, DMA. Each ack goes only to the granted master.
- Read with no valid, TIMEOUT_CYCLES=4: ack with error=1 and readData=32'hDEADBEEF 6 cycles after req. A spurious busReadValid in the following IDLE cycle is ignored.
- Valid in the ISSUE cycle (zero-latency peripheral): ack in cycle 2. Valid coincident with the terminal count: error=0.
- reset_n pulsed low during WAIT: all outputs return to reset values immediately. A late busReadValid after release produces no ack.
